// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 frame receiver.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_t;

    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;

    // 2 ms at 50 MHz
    localparam int unsigned PS2_TIMEOUT_DEFAULT = 100_000;

endpackage

// File: rtl/ps2_clk_filter.sv
// PS/2 line conditioning: 2-flop synchronizers on clock and data, a
// FILTER_LEN-sample glitch filter on the clock, and a registered
// single-cycle pulse on each accepted falling edge of the clock.
module ps2_clk_filter #(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic ps2_clk_raw,
    input  logic ps2_dat_raw,
    output logic clk_fall,
    output logic dat_sync
);

    localparam int unsigned CW = $clog2(FILTER_LEN + 1);

    logic [1:0]    clk_sync;
    logic [1:0]    dat_sync_q;
    logic          clk_filt;
    logic [CW-1:0] cnt;

    assign dat_sync = dat_sync_q[1];

    // Synchronize both raw lines; reset to the idle-high bus level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync   <= 2'b11;
            dat_sync_q <= 2'b11;
        end else begin
            clk_sync   <= {clk_sync[0], ps2_clk_raw};
            dat_sync_q <= {dat_sync_q[0], ps2_dat_raw};
        end
    end

    // Accept a clock level change only after FILTER_LEN consecutive differing samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_filt <= 1'b1;
            cnt      <= '0;
            clk_fall <= 1'b0;
        end else begin
            clk_fall <= 1'b0;
            if (clk_sync[1] == clk_filt) begin
                cnt <= '0;
            end else if (cnt == CW'(FILTER_LEN - 1)) begin
                clk_filt <= clk_sync[1];
                cnt      <= '0;
                // old level high means the accepted change is a fall
                clk_fall <= clk_filt;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/ps2_frame_rx.sv
// PS/2 keyboard frame receiver: 11-bit frames (start, 8 data LSB first,
// odd parity, stop) decoded into bytes behind a one-entry valid/ready
// output register, with parity/frame/overrun error pulses and an
// inter-edge timeout.
// Optional feature macro: PS2_BREAK_FILTER_EN -- swallow the 8'hF0 break
// prefix together with the byte that follows it.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int unsigned CLK_HZ         = 50_000_000,
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = PS2_TIMEOUT_DEFAULT
) (
    input  logic       CLOCK_50,
    input  logic       RESET,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    output logic [7:0] code_data,
    output logic       code_valid,
    input  logic       code_ready,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    if (CLK_HZ == 0 || FILTER_LEN == 0 || TIMEOUT_CYCLES == 0) begin : g_param_check
        $error("ps2_frame_rx: CLK_HZ, FILTER_LEN and TIMEOUT_CYCLES must be non-zero");
    end

    logic          fall;
    logic          dat;
    ps2_state_t    state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          par_bit;
    logic [TW-1:0] tcnt;
`ifdef PS2_BREAK_FILTER_EN
    logic          break_pending;
`endif

    ps2_clk_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_clk_filter (
        .clk         (CLOCK_50),
        .rst         (RESET),
        .ps2_clk_raw (PS2_CLK),
        .ps2_dat_raw (PS2_DAT),
        .clk_fall    (fall),
        .dat_sync    (dat)
    );

    // Frame FSM, timeout counter and registered outputs.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state      <= IDLE;
            bit_cnt    <= 3'd0;
            shift      <= 8'h00;
            par_bit    <= 1'b0;
            tcnt       <= '0;
            code_data  <= 8'h00;
            code_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
`ifdef PS2_BREAK_FILTER_EN
            break_pending <= 1'b0;
`endif
        end else begin
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
            // a load from a good frame below overrides this clear
            if (code_valid && code_ready) begin
                code_valid <= 1'b0;
            end

            if (fall) begin
                tcnt <= '0;
                unique case (state)
                    IDLE: begin
                        if (!dat) begin
                            state <= DATA;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                    DATA: begin
                        shift   <= {dat, shift[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= PARITY;
                        end
                    end
                    PARITY: begin
                        par_bit <= dat;
                        state   <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        if (!dat) begin
                            frame_err <= 1'b1;
                        end else if (!((^shift) ^ par_bit)) begin
                            parity_err <= 1'b1;
                        end else
`ifdef PS2_BREAK_FILTER_EN
                        if (break_pending) begin
                            break_pending <= 1'b0;
                        end else if (shift == PS2_BREAK) begin
                            break_pending <= 1'b1;
                        end else
`endif
                        if (code_valid && !code_ready) begin
                            overrun <= 1'b1;
                        end else begin
                            code_data  <= shift;
                            code_valid <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end else if (state != IDLE) begin
                if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    state     <= IDLE;
                    bit_cnt   <= 3'd0;
                    tcnt      <= '0;
                    frame_err <= 1'b1;
`ifdef PS2_BREAK_FILTER_EN
                    break_pending <= 1'b0;
`endif
                end else begin
                    tcnt <= tcnt + TW'(1);
                end
            end
        end
    end

endmodule
